led_pwm_fader: RTL

- Output stage placed directly downstream of the LED blinker.
- Consumes the blinker's raw on/off LED pattern: 6 on-board LEDs (active-low) plus 1 off-board red LED (active-high).
- Drives the physical pins with PWM dimming and a linear fade on every on/off transition.
- Gives a global brightness limit and replaces hard toggles with soft ramps, without changing the blinker.

---
 rtl/led_pwm_fader.sv | 89 ++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// PWM dimmer with linear per-channel fades between the blinker's raw LED pattern and the pins.
// Latency: 1 cycle input register; a level change reaches the pins at the next PWM period start (+1 cycle).
// Backpressure: none; every input is sampled each cycle.
module led_pwm_fader #(
    parameter int                 N_LEDS              = 7,
    parameter int                 PWM_BITS            = 8,
    parameter int                 FADE_DIV            = 105_000,
    parameter logic [N_LEDS-1:0]  IN_ACTIVE_LOW_MASK  = 7'b0111111,
    parameter logic [N_LEDS-1:0]  OUT_ACTIVE_LOW_MASK = 7'b0111111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LEDS-1:0]   i_led_raw,
    input  logic [PWM_BITS-1:0] i_max_level,
    input  logic                i_fade_en,
    output logic [N_LEDS-1:0]   o_led,
    output logic                o_busy
);

    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [N_LEDS-1:0]   req_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                fade_tick;
    logic [PWM_BITS-1:0] level        [N_LEDS];
    logic [PWM_BITS-1:0] active_level [N_LEDS];
    logic [PWM_BITS-1:0] target       [N_LEDS];
    logic [PWM_BITS-1:0] level_nxt    [N_LEDS];
    logic [N_LEDS-1:0]   lit_nxt;
    logic [N_LEDS-1:0]   lit_q;
    logic [N_LEDS-1:0]   diff;
    logic                busy_q;

    always_comb begin
        fade_tick = (pre_cnt == PRE_LAST);
        for (int i = 0; i < N_LEDS; i++) begin
            target[i]    = req_q[i] ? i_max_level : '0;
            diff[i]      = (level[i] != target[i]);
            lit_nxt[i]   = (pwm_cnt < active_level[i]);
            level_nxt[i] = level[i];
            // Fading steps one level per tick and can never overshoot the target.
            if (!i_fade_en) begin
                level_nxt[i] = target[i];
            end else if (fade_tick) begin
                if (level[i] < target[i]) begin
                    level_nxt[i] = level[i] + PWM_ONE;
                end else if (level[i] > target[i]) begin
                    level_nxt[i] = level[i] - PWM_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pwm_cnt <= '0;
            pre_cnt <= '0;
            lit_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                level[i]        <= '0;
                active_level[i] <= '0;
            end
        end else begin
            req_q   <= i_led_raw ^ IN_ACTIVE_LOW_MASK;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_ONE;
            pre_cnt <= fade_tick ? '0 : pre_cnt + PRE_ONE;
            lit_q   <= lit_nxt;
            busy_q  <= |diff;
            for (int i = 0; i < N_LEDS; i++) begin
                level[i] <= level_nxt[i];
                // Shadow copy keeps the duty constant within one PWM period.
                if (pwm_cnt == '0) begin
                    active_level[i] <= level[i];
                end
            end
        end
    end

    assign o_led  = lit_q ^ OUT_ACTIVE_LOW_MASK;
    assign o_busy = busy_q;

endmodule
